// File: rtl/irq_source_conditioner.sv
// Interrupt source conditioner: per-line synchroniser, glitch filter and polarity, plus a latched
// rising-edge STATUS register. Define IRQ_GLITCH_FILTER_EN to include the programmable glitch filter.
module irq_source_conditioner #(
  parameter int NUM_IRQ      = 8,
  parameter int SYNC_STAGES  = 2,
  parameter int FILTER_BITS  = 4,
  parameter int FILTER_RESET = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_raw,
  output logic [NUM_IRQ-1:0] irq_out,
  input  logic [7:0]         i_data,
  output logic [7:0]         o_data,
  input  logic [1:0]         addr,
  input  logic               cs,
  input  logic               rwb
);

  logic                                 we;
  logic                                 re;
  logic [SYNC_STAGES-1:0][NUM_IRQ-1:0]  sync_q;
  logic [NUM_IRQ-1:0]                   sync_s;
  logic [NUM_IRQ-1:0]                   filt;
  logic [NUM_IRQ-1:0]                   polarity;
  logic [NUM_IRQ-1:0]                   status;
  logic [NUM_IRQ-1:0]                   prev_out;
  logic [NUM_IRQ-1:0]                   w1c;

  assign we      = cs & ~rwb;
  assign re      = cs & rwb;
  assign sync_s  = sync_q[SYNC_STAGES-1];
  assign irq_out = filt ^ polarity;
  assign w1c     = (we && addr == 2'd2) ? i_data[NUM_IRQ-1:0] : '0;

  // Synchroniser chain: stage 0 captures the raw asynchronous lines.
  always_ff @(negedge clk) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], irq_raw};
    end
  end

`ifdef IRQ_GLITCH_FILTER_EN
  localparam logic [FILTER_BITS-1:0] CNT_ONE = FILTER_BITS'(1);

  logic [FILTER_BITS-1:0]               filter_len;
  logic [NUM_IRQ-1:0][FILTER_BITS-1:0]  cnt;

  // A line must disagree with filt for FILTER_LEN+1 consecutive samples before filt follows;
  // any bounce back restarts the count. cnt wraps rather than saturates if LEN shrinks mid-count.
  always_ff @(negedge clk) begin
    if (reset) begin
      filt <= '0;
      cnt  <= '0;
    end else begin
      for (int i = 0; i < NUM_IRQ; i++) begin
        if (sync_s[i] == filt[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == filter_len) begin
          filt[i] <= sync_s[i];
          cnt[i]  <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_ONE;
        end
      end
    end
  end
`else
  always_ff @(negedge clk) begin
    if (reset) begin
      filt <= '0;
    end else begin
      filt <= sync_s;
    end
  end
`endif

  // CPU registers; a fresh rising edge takes priority over a simultaneous W1C on the same bit.
  always_ff @(negedge clk) begin
    if (reset) begin
      polarity <= '0;
      status   <= '0;
      prev_out <= '0;
`ifdef IRQ_GLITCH_FILTER_EN
      filter_len <= FILTER_BITS'(FILTER_RESET);
`endif
    end else begin
      prev_out <= irq_out;
      status   <= (status & ~w1c) | (irq_out & ~prev_out);
      if (we && addr == 2'd0) begin
        polarity <= i_data[NUM_IRQ-1:0];
      end
`ifdef IRQ_GLITCH_FILTER_EN
      if (we && addr == 2'd1) begin
        filter_len <= i_data[FILTER_BITS-1:0];
      end
`endif
    end
  end

  always_comb begin
    o_data = 8'h00;
    if (re) begin
      case (addr)
        2'd0:    o_data = 8'(polarity);
`ifdef IRQ_GLITCH_FILTER_EN
        2'd1:    o_data = 8'(filter_len);
`else
        2'd1:    o_data = 8'h00;
`endif
        2'd2:    o_data = 8'(status);
        default: o_data = 8'(irq_out);
      endcase
    end
  end

endmodule
